bcd2_down_timer: RTL and testbench
==================================

BCD2_DOWN_TIMER -- requirements
Module: bcd2_down_timer

Interface
REQ-001 SHALL have port CK, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port AR, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port CE, input, 1 bit: count enable; decrements only when high.
REQ-004 SHALL have port LD, input, 1 bit: synchronous load strobe.
REQ-005 SHALL have port D, input, 8 bits: load value, two BCD digits {tens, ones}.
REQ-006 SHALL have port Q, output, 8 bits: current count, two BCD digits {tens, ones}.
REQ-007 SHALL have port BO, output, 1 bit: borrow-out, a one-cycle pulse on terminal count.
REQ-008 SHALL have port DONE, output, 1 bit: high while in DONE state.
REQ-009 SHALL have port RUN, output, 1 bit: high while in RUN state.

Function
REQ-010 SHALL implement FSM states IDLE, RUN, DONE; Q, BO, DONE, RUN all registered.
REQ-011 LD=1 at an edge, in any state, SHALL set Q<=D and go to RUN, or to DONE if D==00; LD has priority over CE.
REQ-012 At load, any digit of D above 9 SHALL be clamped to 9 (e.g. D=8'hAF loads 99).
REQ-013 In RUN with CE=1 and LD=0, Q SHALL decrement by 1 in BCD: ones 0->9 with a borrow to tens; tens decrements only on that borrow.
REQ-014 In RUN with CE=0, Q SHALL hold.
REQ-015 In RUN with Q==01 and CE=1: Q<=00, state<=DONE, and BO SHALL be 1 for exactly the following cycle.
REQ-016 In IDLE and DONE, CE SHALL be ignored and Q held; DONE exits only via LD or AR.
REQ-017 BO SHALL be 0 at all times except the cycle specified in REQ-015 (or REQ-024).
REQ-018 LD coincident with the terminal decrement SHALL win: load takes effect, BO stays 0.
REQ-019 Q SHALL never hold a non-BCD digit value.

Reset
REQ-020 AR=0 SHALL immediately force Q=00, BO=0, DONE=0, RUN=0, state IDLE, and reload register=00, regardless of CK.
REQ-021 AR asserted mid-count SHALL abort the count; after AR releases, the block SHALL stay in IDLE until LD.
REQ-022 LD, CE and D SHALL have no effect while AR=0.

Configuration
REQ-023 Macro BCD_DOWN_AUTORELOAD_EN SHALL select auto-reload; the block SHALL store the clamped D in a reload register on every LD.
REQ-024 With BCD_DOWN_AUTORELOAD_EN defined, the REQ-015 event SHALL set Q<=reload value, stay in RUN and pulse BO; DONE is entered only via a load of 00.
REQ-025 Without the macro, REQ-015 applies as written and no reload register SHALL exist.

Structure
REQ-026 Shared package bcd_timer_pkg SHALL hold the state enum (IDLE/RUN/DONE), BCD_MAX=4'd9 and the digit width constant 4.
REQ-027 The block SHALL use one sub-module, bcd_down_digit (ports CK, AR, CE, LD, D[3:0], Q[3:0], BZ, where BZ = Q==0 & CE), instantiated twice and chained ones -> tens by BZ.

Verification
REQ-028 AR pulse low, then LD with D=8'h12, then CE=1 for 12 cycles -> Q steps 12,11,10,09,...,01,00; BO pulses once at the cycle after 00; DONE=1 after that.
REQ-029 LD D=8'h20, CE=1 for 1 cycle -> Q=19 (tens borrow); CE=0 for 5 cycles -> Q holds 19 with RUN=1.
REQ-030 LD D=8'hAF -> Q=99; LD D=8'h00 -> Q=00, DONE=1, BO=0.
REQ-031 Q=03 while counting, AR low between clock edges -> Q=00 and IDLE immediately; CE=1 after release -> Q stays 00.
REQ-032 Q=01, CE=1 and LD=1 with D=8'h05 on the same edge -> Q=05, RUN=1, BO=0.
REQ-033 With BCD_DOWN_AUTORELOAD_EN, LD D=8'h02, CE=1 for 6 cycles -> Q sequence 01,00->02 reload,01,02...: BO pulses every 2nd decrement, DONE never set.

Source files
------------

// File: rtl/bcd_timer_pkg.sv
// Shared types and constants for the two-digit BCD down timer.
package bcd_timer_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } timer_state_t;

    // Any nibble above 9 is treated as 9 so a loaded digit is always valid BCD.
    function automatic logic [DIGIT_W-1:0] bcd_clamp(input logic [DIGIT_W-1:0] digit);
        return (digit > BCD_MAX) ? BCD_MAX : digit;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit: load (clamped), decrement with 0->9 wrap,
// and a borrow flag BZ to enable the next-higher digit.
module bcd_down_digit
    import bcd_timer_pkg::*;
(
    input  logic               CK,
    input  logic               AR,
    input  logic               CE,
    input  logic               LD,
    input  logic [DIGIT_W-1:0] D,
    output logic [DIGIT_W-1:0] Q,
    output logic               BZ
);

    always_ff @(posedge CK or negedge AR) begin
        if (!AR) begin
            Q <= '0;
        end else if (LD) begin
            Q <= bcd_clamp(D);
        end else if (CE) begin
            Q <= (Q == '0) ? BCD_MAX : (Q - 4'd1);
        end
    end

    assign BZ = (Q == '0) & CE;

endmodule

// File: rtl/bcd2_down_timer.sv
// Two-digit BCD down timer with IDLE/RUN/DONE control and a borrow-out pulse.
// Define BCD_DOWN_AUTORELOAD_EN to reload the last loaded value at terminal count.
module bcd2_down_timer
    import bcd_timer_pkg::*;
(
    input  logic       CK,
    input  logic       AR,
    input  logic       CE,
    input  logic       LD,
    input  logic [7:0] D,
    output logic [7:0] Q,
    output logic       BO,
    output logic       DONE,
    output logic       RUN
);

    timer_state_t state, state_next;
    logic         bo_next;
    logic [7:0]   d_clamped;
    logic         load_zero;
    logic         count_en;
    logic         terminal;
    logic         end_of_count;
    logic         digit_ld;
    logic [7:0]   digit_d;
    logic         ones_bz;
    logic         tens_bz;

    assign d_clamped = {bcd_clamp(D[7:4]), bcd_clamp(D[3:0])};
    assign load_zero = (d_clamped == 8'h00);

    // Q==00 is excluded so the digit chain can never wrap to 99 from RUN.
    assign count_en = (state == ST_RUN) & CE & ~LD & (Q != 8'h00);
    assign terminal = count_en & (Q == 8'h01);
    assign end_of_count = terminal | tens_bz;

`ifdef BCD_DOWN_AUTORELOAD_EN
    logic [7:0] reload;

    always_ff @(posedge CK or negedge AR) begin
        if (!AR) begin
            reload <= 8'h00;
        end else if (LD) begin
            reload <= d_clamped;
        end
    end

    assign digit_ld = LD | terminal;
    assign digit_d  = LD ? D : reload;
`else
    assign digit_ld = LD;
    assign digit_d  = D;
`endif

    bcd_down_digit u_ones (
        .CK (CK),
        .AR (AR),
        .CE (count_en),
        .LD (digit_ld),
        .D  (digit_d[3:0]),
        .Q  (Q[3:0]),
        .BZ (ones_bz)
    );

    bcd_down_digit u_tens (
        .CK (CK),
        .AR (AR),
        .CE (ones_bz),
        .LD (digit_ld),
        .D  (digit_d[7:4]),
        .Q  (Q[7:4]),
        .BZ (tens_bz)
    );

    always_ff @(posedge CK or negedge AR) begin
        if (!AR) begin
            state <= ST_IDLE;
            BO    <= 1'b0;
            DONE  <= 1'b0;
            RUN   <= 1'b0;
        end else begin
            state <= state_next;
            BO    <= bo_next;
            DONE  <= (state_next == ST_DONE);
            RUN   <= (state_next == ST_RUN);
        end
    end

    always_comb begin
        state_next = state;
        bo_next    = 1'b0;
        if (LD) begin
            state_next = load_zero ? ST_DONE : ST_RUN;
        end else if ((state == ST_RUN) && end_of_count) begin
            bo_next = 1'b1;
`ifdef BCD_DOWN_AUTORELOAD_EN
            state_next = ST_RUN;
`else
            state_next = ST_DONE;
`endif
        end
    end

endmodule

// File: tb/tb_bcd2_down_timer.sv
// Directed plus randomized bench for bcd2_down_timer against an integer reference model.
module tb_bcd2_down_timer;

    logic       CK;
    logic       AR;
    logic       CE;
    logic       LD;
    logic [7:0] D;
    logic [7:0] Q;
    logic       BO;
    logic       DONE;
    logic       RUN;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: count as a plain integer 0..99, state 0=idle 1=run 2=done
    int m_cnt;
    int m_state;
    int m_bo;
    int m_reload;

    bcd2_down_timer dut (
        .CK   (CK),
        .AR   (AR),
        .CE   (CE),
        .LD   (LD),
        .D    (D),
        .Q    (Q),
        .BO   (BO),
        .DONE (DONE),
        .RUN  (RUN)
    );

    initial begin
        CK = 1'b0;
        forever #5 CK = ~CK;
    end

    function automatic int clamp9(input int v);
        return (v > 9) ? 9 : v;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(v / 10);
        o = 4'(v % 10);
        return {t, o};
    endfunction

    task automatic model_reset();
        m_cnt    = 0;
        m_state  = 0;
        m_bo     = 0;
        m_reload = 0;
    endtask

    task automatic model_edge();
        int v;
        if (AR) begin
            m_bo = 0;
            if (LD) begin
                v        = clamp9(int'(D[7:4])) * 10 + clamp9(int'(D[3:0]));
                m_cnt    = v;
                m_reload = v;
                m_state  = (v == 0) ? 2 : 1;
            end else if (m_state == 1 && CE) begin
                if (m_cnt == 1) begin
                    m_bo = 1;
`ifdef BCD_DOWN_AUTORELOAD_EN
                    m_cnt = m_reload;
`else
                    m_cnt   = 0;
                    m_state = 2;
`endif
                end else begin
                    m_cnt = m_cnt - 1;
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".Q"},    Q,            to_bcd(m_cnt));
        check({tag, ".BO"},   {7'd0, BO},   8'(m_bo));
        check({tag, ".DONE"}, {7'd0, DONE}, 8'(m_state == 2));
        check({tag, ".RUN"},  {7'd0, RUN},  8'(m_state == 1));
    endtask

    task automatic tick(input string tag);
        @(posedge CK);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic async_reset_pulse(input string tag);
        AR = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        #1;
        AR = 1'b1;
    endtask

    initial begin
        AR = 1'b0;
        CE = 1'b0;
        LD = 1'b0;
        D  = 8'h00;
        model_reset();
        #12;
        check_all("reset");
        check("reset_q_const", Q, 8'h00);
        AR = 1'b1;
        tick("idle_after_reset");

        // 12 counts down to 00 with one borrow-out pulse
        LD = 1'b1; D = 8'h12;
        tick("load12");
        LD = 1'b0; CE = 1'b1;
        for (int i = 0; i < 12; i++) tick("count12");
`ifndef BCD_DOWN_AUTORELOAD_EN
        check("req028_q",    Q,            8'h00);
        check("req028_bo",   {7'd0, BO},   8'h01);
        check("req028_done", {7'd0, DONE}, 8'h01);
`endif
        tick("after_terminal");
`ifndef BCD_DOWN_AUTORELOAD_EN
        check("req028_bo_clear", {7'd0, BO}, 8'h00);
`endif

        // Tens borrow, then hold with CE low
        CE = 1'b0; LD = 1'b1; D = 8'h20;
        tick("load20");
        LD = 1'b0; CE = 1'b1;
        tick("borrow20");
        check("req029_q", Q, 8'h19);
        CE = 1'b0;
        for (int i = 0; i < 5; i++) tick("hold19");
        check("req029_hold", Q, 8'h19);

        // Clamp and load of zero
        LD = 1'b1; D = 8'hAF;
        tick("loadAF");
        check("req030_clamp", Q, 8'h99);
        D = 8'h00;
        tick("load00");
        check("req030_done", {7'd0, DONE}, 8'h01);

        // Async reset mid-count, then CE ignored in IDLE
        D = 8'h05;
        tick("load05");
        LD = 1'b0; CE = 1'b1;
        tick("cnt04");
        tick("cnt03");
        check("req031_pre", Q, 8'h03);
        async_reset_pulse("midcount_reset");
        check("req031_q", Q, 8'h00);
        for (int i = 0; i < 3; i++) tick("idle_ce");

        // Load coincident with terminal decrement wins
        CE = 1'b0; LD = 1'b1; D = 8'h02;
        tick("load02");
        LD = 1'b0; CE = 1'b1;
        tick("cnt01");
        LD = 1'b1; D = 8'h05;
        tick("ld_vs_term");
        check("req032_q",  Q,          8'h05);
        check("req032_bo", {7'd0, BO}, 8'h00);

`ifdef BCD_DOWN_AUTORELOAD_EN
        D = 8'h02;
        tick("ar_load02");
        LD = 1'b0; CE = 1'b1;
        for (int i = 0; i < 6; i++) tick("autoreload");
        check("req033_done", {7'd0, DONE}, 8'h00);
`endif

        // Randomized traffic biased toward small loads so terminal counts occur
        LD = 1'b0; CE = 1'b0;
        for (int i = 0; i < 400; i++) begin
            LD = ($urandom_range(0, 11) == 0);
            CE = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 3))
                0:       D = 8'($urandom);
                1:       D = 8'h00;
                default: D = {4'h0, 4'($urandom_range(1, 9))};
            endcase
            if ($urandom_range(0, 59) == 0) async_reset_pulse("rand_reset");
            tick("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
